// File: rtl/gpio_input_conditioner.sv
// Synchronises and debounces board KEY/SW pins into the SoC GPIO input word.
// Also emits one-cycle key-press and switch-change pulses once valid.
module gpio_input_conditioner #(
  parameter int clk_mhz      = 50,
  parameter int w_key        = 4,
  parameter int w_sw         = 18,
  parameter int tick_cycles  = clk_mhz * 1000,
  parameter int stable_ticks = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [w_key-1:0] key,
  input  logic [w_sw-1:0]  sw,
  output logic [31:0]      gpio_in,
  output logic [w_key-1:0] key_pressed,
  output logic             sw_changed,
  output logic             valid
);

  localparam int W  = w_key + w_sw;
  localparam int PW = $clog2(tick_cycles);
  localparam int CW = (stable_ticks > 1) ? $clog2(stable_ticks) : 1;

  localparam logic [W-1:0]  RST_V = {{w_key{1'b1}}, {w_sw{1'b0}}};
  localparam logic [PW-1:0] P_MAX = PW'(tick_cycles - 1);
  localparam logic [CW-1:0] C_MAX = CW'(stable_ticks - 1);

  logic [W-1:0]     meta;
  logic [W-1:0]     sync;
  logic [W-1:0]     db;
  logic [W-1:0]     commit;
  logic [CW-1:0]    cnt [W];
  logic [PW-1:0]    pcnt;
  logic [CW-1:0]    tcnt;
  logic             tick;
  logic [w_key-1:0] fall_r;
  logic             sw_chg_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_V;
      sync <= RST_V;
    end else begin
      meta <= {key, sw};
      sync <= meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (pcnt == P_MAX) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick = (pcnt == P_MAX);

  always_comb begin
    commit = '0;
    for (int i = 0; i < W; i++) begin
      commit[i] = tick && (sync[i] != db[i]) && (cnt[i] == C_MAX);
    end
  end

  // Any equal sample restarts qualification; cnt clears on commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= RST_V;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < W; i++) begin
        if (sync[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (commit[i]) begin
          db[i]  <= sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt  <= '0;
      valid <= 1'b0;
    end else if (tick && !valid) begin
      if (tcnt == C_MAX) begin
        valid <= 1'b1;
      end else begin
        tcnt <= tcnt + CW'(1);
      end
    end
  end

  // Mask with pre-edge valid so power-up commits never pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fall_r      <= '0;
      sw_chg_r    <= 1'b0;
      key_pressed <= '0;
      sw_changed  <= 1'b0;
    end else begin
      fall_r      <= {w_key{valid}} & commit[W-1:w_sw] & db[W-1:w_sw];
      sw_chg_r    <= valid & (|commit[w_sw-1:0]);
      key_pressed <= fall_r;
      sw_changed  <= sw_chg_r;
    end
  end

  assign gpio_in = 32'(db);

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output events,
// a monitor pops one per observed output change and checks value and cycle.
module tb_gpio_input_conditioner;

  logic        clk;
  logic        reset;
  logic [3:0]  key;
  logic [17:0] sw;
  logic [31:0] gpio_in;
  logic [3:0]  key_pressed;
  logic        sw_changed;
  logic        valid;

  gpio_input_conditioner #(
    .clk_mhz(50),
    .w_key(4),
    .w_sw(18),
    .tick_cycles(4),
    .stable_ticks(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .sw(sw),
    .gpio_in(gpio_in),
    .key_pressed(key_pressed),
    .sw_changed(sw_changed),
    .valid(valid)
  );

  typedef struct {
    string       name;
    logic [31:0] g;
    logic [3:0]  kp;
    logic        sc;
    logic        v;
    bit          rel;
    int          lo;
    int          hi;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   t;
  int   r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // A reset assertion is an event even if outputs happen not to move.
  initial begin
    logic [37:0] obs;
    logic [37:0] prev;
    logic        prev_rst;
    exp_t        e;
    int          lo;
    int          hi;
    prev     = 'x;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      obs = {gpio_in, key_pressed, sw_changed, valid};
      if (obs !== prev || (reset && !prev_rst)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event g=%h kp=%b sc=%b v=%b at %0d",
                   gpio_in, key_pressed, sw_changed, valid, cyc);
        end else begin
          e  = q.pop_front();
          lo = e.rel ? last_cyc + e.lo : e.lo;
          hi = e.rel ? last_cyc + e.hi : e.hi;
          if ({e.g, e.kp, e.sc, e.v} !== obs || cyc < lo || cyc > hi) begin
            errors++;
            $display("FAIL %s got g=%h kp=%b sc=%b v=%b at %0d want g=%h kp=%b sc=%b v=%b in [%0d,%0d]",
                     e.name, gpio_in, key_pressed, sw_changed, valid, cyc,
                     e.g, e.kp, e.sc, e.v, lo, hi);
          end
        end
        last_cyc = cyc;
      end
      prev     = obs;
      prev_rst = reset;
    end
  end

  task automatic push(input string name, input logic [31:0] g,
                      input logic [3:0] kp, input logic sc, input logic v,
                      input bit rel, input int lo, input int hi);
    exp_t e;
    e.name = name;
    e.g    = g;
    e.kp   = kp;
    e.sc   = sc;
    e.v    = v;
    e.rel  = rel;
    e.lo   = lo;
    e.hi   = hi;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int n);
    int k;
    k = 0;
    while (q.size() != 0 && k < n) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout pending=%0d want 0", name, q.size());
      q.delete();
    end
  endtask

  // Commit lands 11..14 cycles after the pin change.
  task automatic commit_quiet(input string name, input logic [31:0] g);
    push(name, g, 4'b0, 1'b0, 1'b1, 1'b0, cyc + 11, cyc + 14);
  endtask

  task automatic commit_sw(input string name, input logic [31:0] g);
    commit_quiet(name, g);
    push({name, "_pulse"}, g, 4'b0, 1'b1, 1'b1, 1'b1, 1, 1);
    push({name, "_end"}, g, 4'b0, 1'b0, 1'b1, 1'b1, 1, 1);
  endtask

  task automatic commit_key(input string name, input logic [31:0] g,
                            input logic [3:0] kp);
    commit_quiet(name, g);
    push({name, "_pulse"}, g, kp, 1'b0, 1'b1, 1'b1, 1, 1);
    push({name, "_end"}, g, 4'b0, 1'b0, 1'b1, 1'b1, 1, 1);
  endtask

  initial begin
    reset = 1'b1;
    key   = 4'hF;
    sw    = '0;
    push("rst0", 32'h003C_0000, 4'b0, 1'b0, 1'b0, 1'b0, 0, 1 << 30);
    step(3);
    reset = 1'b0;
    r = cyc;
    push("valid_up", 32'h003C_0000, 4'b0, 1'b0, 1'b1, 1'b0, r + 12, r + 12);
    drain("valid_up", 40);
    step(5);

    reset = 1'b1;
    sw    = 18'h00001;
    t = cyc;
    push("rst1", 32'h003C_0000, 4'b0, 1'b0, 1'b0, 1'b0, t, t);
    step(2);
    reset = 1'b0;
    r = cyc;
    push("pwr_sw", 32'h003C_0001, 4'b0, 1'b0, 1'b1, 1'b0, r + 12, r + 12);
    drain("pwr_sw", 40);
    step(20);

    sw[5] = 1'b1;
    commit_sw("sw5", 32'h003C_0021);
    drain("sw5", 40);
    step(20);

    key[2] = 1'b0;
    commit_key("key2", 32'h002C_0021, 4'b0100);
    drain("key2", 40);
    step(10);
    key[2] = 1'b1;
    commit_quiet("key2_rel", 32'h003C_0021);
    drain("key2_rel", 40);
    step(20);

    key[1] = 1'b0;
    step(6);
    key[1] = 1'b1;
    step(30);

    key = 4'b0110;
    commit_key("key03", 32'h0018_0021, 4'b1001);
    drain("key03", 40);
    step(10);
    key = 4'hF;
    commit_quiet("key03_rel", 32'h003C_0021);
    drain("key03_rel", 40);
    step(20);

    sw[0] = 1'b0;
    commit_sw("sw0_off", 32'h003C_0020);
    drain("sw0_off", 40);
    step(20);

    sw[0] = 1'b1;
    step(10);
    reset = 1'b1;
    t = cyc;
    push("rst2", 32'h003C_0000, 4'b0, 1'b0, 1'b0, 1'b0, t, t);
    step(1);
    reset = 1'b0;
    r = cyc;
    push("requal", 32'h003C_0021, 4'b0, 1'b0, 1'b1, 1'b0, r + 12, r + 12);
    drain("requal", 40);
    step(30);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_empty got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
